// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo-MOD counter with parallel load, saturate/wrap mode and cascade output.
// Ports:
//   clk  - rising-edge clock
//   nrst - synchronous active-low reset (q=0, wrap=0, ovf=0)
//   en   - count enable
//   load - parallel-load strobe (q <= d, clamped to MOD-1)
//   d    - parallel-load value
//   up   - direction, 1 = up, 0 = down
//   sat  - boundary mode, 1 = saturate, 0 = wrap
//   q    - registered count, always in 0..MOD-1
//   tc   - combinational terminal count for chaining into the next stage's en
//   wrap - registered one-cycle pulse after a modulus wrap
//   ovf  - registered sticky overflow/underflow flag, cleared by reset or load
module updown_mod_counter #(
  parameter int N   = 3,
  parameter int MOD = 2**N
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         up,
  input  logic         sat,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap,
  output logic         ovf
);
  localparam logic [N-1:0] MAX = N'(MOD - 1);
  logic [N-1:0] r_q;
  logic         r_wrap;
  logic         r_ovf;
  logic         w_bound;
  logic [N-1:0] w_load_q;
  logic [N-1:0] w_step_q;
  // boundary in the current direction: top when counting up, zero when counting down
  assign w_bound  = up ? (r_q == MAX) : (r_q == '0);
  // compare in N+1 bits so MOD == 2**N is representable
  assign w_load_q = ({1'b0, d} < (N+1)'(MOD)) ? d : MAX;
  assign w_step_q = w_bound ? (sat ? r_q : (up ? '0 : MAX))
                            : (up ? r_q + N'(1) : r_q - N'(1));
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q    <= load ? w_load_q : (en ? w_step_q : r_q);
      r_wrap <= ~load & en & w_bound & ~sat;
      r_ovf  <= ~load & (r_ovf | (en & w_bound));
    end
  end
  assign q    = r_q;
  assign tc   = en & ~load & w_bound;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: scoreboard bench for updown_mod_counter (MOD=6, full-range MOD=8, and a MOD=10 cascade).
module tb_updown_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       nrst, en, load, up, sat;
  logic [2:0] d;
  logic [2:0] qa, qb;
  logic       tca, tcb, wa, wb, oa, ob;
  logic       c_nrst;
  logic [3:0] lq, hq;
  logic       ltc, htc, lw, hw, lo, ho;
  int vectors = 0;
  int errs = 0;
  bit c_done = 0;
  updown_mod_counter #(.N(3), .MOD(6)) u_a (
    .clk(clk), .nrst(nrst), .en(en), .load(load), .d(d), .up(up), .sat(sat),
    .q(qa), .tc(tca), .wrap(wa), .ovf(oa));
  updown_mod_counter #(.N(3)) u_b (
    .clk(clk), .nrst(nrst), .en(en), .load(load), .d(d), .up(up), .sat(sat),
    .q(qb), .tc(tcb), .wrap(wb), .ovf(ob));
  updown_mod_counter #(.N(4), .MOD(10)) u_lo (
    .clk(clk), .nrst(c_nrst), .en(1'b1), .load(1'b0), .d(4'd0), .up(1'b1), .sat(1'b0),
    .q(lq), .tc(ltc), .wrap(lw), .ovf(lo));
  updown_mod_counter #(.N(4), .MOD(10)) u_hi (
    .clk(clk), .nrst(c_nrst), .en(ltc), .load(1'b0), .d(4'd0), .up(1'b1), .sat(1'b0),
    .q(hq), .tc(htc), .wrap(hw), .ovf(ho));
  typedef struct {int q; bit w; bit o;} st_t;
  typedef struct {bit tca; bit tcb; int qa0; int qb0; st_t na; st_t nb;} item_t;
  item_t sb[$];
  st_t ma = '{-1, 0, 0};
  st_t mb = '{-1, 0, 0};
  function automatic st_t nxt(st_t s, int m, bit rn, bit ld, int dv, bit e, bit u, bit sa);
    st_t r;
    bit at_edge;
    r = s;
    r.w = 0;
    at_edge = u ? (s.q == m - 1) : (s.q == 0);
    if (!rn) begin
      r.q = 0;
      r.o = 0;
    end else if (ld) begin
      r.q = (dv < m) ? dv : m - 1;
      r.o = 0;
    end else if (e) begin
      if (at_edge) r.o = 1;
      if (!(at_edge && sa)) begin
        r.q = (s.q + (u ? 1 : m - 1)) % m;
        r.w = at_edge;
      end
    end
    return r;
  endfunction
  function automatic bit tc_of(int q, int m, bit ld, bit e, bit u);
    return e && !ld && (u ? q == m - 1 : q == 0);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input bit rn, input bit ld, input int dv, input bit e, input bit u, input bit sa);
    item_t it;
    @(negedge clk);
    nrst = rn; load = ld; d = dv[2:0]; en = e; up = u; sat = sa;
    it.tca = tc_of(ma.q, 6, ld, e, u);
    it.tcb = tc_of(mb.q, 8, ld, e, u);
    it.qa0 = ma.q;
    it.qb0 = mb.q;
    ma = nxt(ma, 6, rn, ld, dv, e, u, sa);
    mb = nxt(mb, 8, rn, ld, dv, e, u, sa);
    it.na = ma;
    it.nb = mb;
    sb.push_back(it);
  endtask
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk("tc_a", {31'b0, tca}, {31'b0, it.tca});
        chk("tc_b", {31'b0, tcb}, {31'b0, it.tcb});
        if (it.qa0 >= 0) chk("q_hold_a", {29'b0, qa}, it.qa0);
        if (it.qb0 >= 0) chk("q_hold_b", {29'b0, qb}, it.qb0);
        @(posedge clk);
        #1;
        chk("q_a", {29'b0, qa}, it.na.q);
        chk("wrap_a", {31'b0, wa}, {31'b0, it.na.w});
        chk("ovf_a", {31'b0, oa}, {31'b0, it.na.o});
        chk("q_b", {29'b0, qb}, it.nb.q);
        chk("wrap_b", {31'b0, wb}, {31'b0, it.nb.w});
        chk("ovf_b", {31'b0, ob}, {31'b0, it.nb.o});
      end
    end
  end
  initial begin
    c_nrst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("cascade_reset", {24'b0, hq, lq}, 0);
    @(negedge clk);
    c_nrst = 1'b1;
    for (int i = 1; i <= 205; i++) begin
      @(posedge clk);
      #1;
      chk("cascade_count", hq * 10 + lq, i % 100);
    end
    c_done = 1;
  end
  initial begin
    nrst = 1'b0; en = 1'b0; load = 1'b0; d = '0; up = 1'b0; sat = 1'b0;
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (7) step(1, 0, 0, 1, 1, 0);
    step(1, 1, 2, 0, 0, 0);
    repeat (4) step(1, 0, 0, 1, 0, 1);
    step(1, 1, 7, 1, 1, 0);
    step(1, 1, 3, 1, 1, 0);
    step(1, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 1, 2, 1, 1, 0);
    step(1, 1, 7, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    repeat (300)
      step($urandom_range(31) != 0, $urandom_range(7) == 0, int'($urandom_range(7)),
           $urandom_range(3) != 0, 1'($urandom), $urandom_range(3) == 0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      errs++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    for (int k = 0; k < 400 && !c_done; k++) @(posedge clk);
    if (!c_done) begin
      errs++;
      $display("FAIL cascade_timeout: done=0 expected 1");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
